// File: rtl/irq_ctrl.sv
// Interrupt controller: N_SRC synchronised sources, edge/level pending, mask, global enable, Wishbone regs.
// Latency: edge request reaches INT four edges after it is driven; register writes show on INT/CAUSE one edge later.
// Backpressure: none; every request is acknowledged on the following cycle and STB held high completes every second cycle.
module irq_ctrl #(
    parameter int          N_SRC      = 8,
    parameter logic [31:0] EDGE_SEL   = 32'h0000_00FF,
    parameter logic [31:0] CAUSE_BASE = 32'h0000_0003
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             STB,
    input  logic             WE,
    input  logic [31:0]      ADDR,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    output logic             ACK,
    output logic             INT,
    output logic [31:0]      CAUSE
);
    localparam logic [N_SRC-1:0] EDGE_MASK = EDGE_SEL[N_SRC-1:0];

    logic [N_SRC-1:0] s1, s2, p;
    logic [N_SRC-1:0] pending, mask;
    logic             gen;

    logic             req, wr;
    logic [1:0]       word;
    logic [N_SRC-1:0] set, w1c, active, pending_nxt;
    logic [31:0]      pending_ext, mask_ext, rd_dat;
    logic             int_nxt;
    logic [31:0]      cause_nxt;
    logic             unused_bits;

    assign req  = STB & ~ACK;
    assign wr   = req & WE;
    assign word = ADDR[3:2];

    assign set    = s2 & ~p;
    assign w1c    = (wr && word == 2'd0) ? DAT_I[N_SRC-1:0] : '0;
    assign active = pending & mask;

    // A new edge in the same cycle as its W1C keeps the bit set; level bits simply follow s2.
    assign pending_nxt = (EDGE_MASK & ((pending & ~w1c) | set)) | (~EDGE_MASK & s2);

    assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I};

    always_comb begin
        pending_ext                = '0;
        mask_ext                   = '0;
        rd_dat                     = '0;
        pending_ext[N_SRC-1:0]     = pending;
        mask_ext[N_SRC-1:0]        = mask;
        case (word)
            2'd0:    rd_dat = pending_ext;
            2'd1:    rd_dat = mask_ext;
            2'd2:    rd_dat = CAUSE;
            default: rd_dat = {16'h0, 8'(N_SRC), 7'h0, gen};
        endcase
    end

    // Scan from the top so the lowest active index is the last one written.
    always_comb begin
        int_nxt   = gen & (|active);
        cause_nxt = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) cause_nxt = CAUSE_BASE + 32'(i);
        end
        if (!gen) cause_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            s1      <= '0;
            s2      <= '0;
            p       <= '0;
            pending <= '0;
            mask    <= '0;
            gen     <= 1'b0;
            ACK     <= 1'b0;
            DAT_O   <= '0;
            INT     <= 1'b0;
            CAUSE   <= '0;
        end else begin
            s1      <= irq_in;
            s2      <= s1;
            p       <= s2;
            pending <= pending_nxt;
            if (wr && word == 2'd1) mask <= DAT_I[N_SRC-1:0];
            if (wr && word == 2'd3) gen  <= DAT_I[0];
            ACK     <= req;
            DAT_O   <= (req && !WE) ? rd_dat : '0;
            INT     <= int_nxt;
            CAUSE   <= cause_nxt;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl with sources 0..6 edge-latched and source 7 level-sensitive.
module tb_irq_ctrl;
    localparam int N = 8;
    localparam logic [N-1:0] EDGE = 8'h7F;

    logic         clk = 1'b0;
    logic         RSTN = 1'b0;
    logic [N-1:0] irq_in = '0;
    logic         STB = 1'b0;
    logic         WE = 1'b0;
    logic [31:0]  ADDR = '0;
    logic [31:0]  DAT_I = '0;
    logic [31:0]  DAT_O;
    logic         ACK;
    logic         INT;
    logic [31:0]  CAUSE;

    irq_ctrl #(.N_SRC(N), .EDGE_SEL(32'h0000_007F), .CAUSE_BASE(32'h0000_0003)) dut (
        .clk(clk), .RSTN(RSTN), .irq_in(irq_in), .STB(STB), .WE(WE), .ADDR(ADDR),
        .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK(ACK), .INT(INT), .CAUSE(CAUSE)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raw samples of irq_in kept as a short history.
    logic [N-1:0] hist [3];
    logic [N-1:0] m_pend = '0, m_mask = '0;
    logic         m_gen = 1'b0, m_ack = 1'b0, m_int = 1'b0;
    logic [31:0]  m_dat = '0, m_cause = '0;

    function automatic logic [31:0] cause_of(input logic g, input logic [N-1:0] act);
        int k;
        if (!g || act == '0) return 32'h0;
        k = 0;
        while (!act[k]) k++;
        return 32'h3 + 32'(k);
    endfunction

    always @(posedge clk) begin : model
        logic         req;
        logic [31:0]  rv;
        logic [N-1:0] w1c, rise;
        if (!RSTN) begin
            hist[0] = '0; hist[1] = '0; hist[2] = '0;
            m_pend = '0; m_mask = '0; m_gen = 1'b0;
            m_ack = 1'b0; m_dat = '0; m_int = 1'b0; m_cause = '0;
        end else begin
            req = STB && !m_ack;
            case (ADDR[3:2])
                2'd0:    rv = {24'h0, m_pend};
                2'd1:    rv = {24'h0, m_mask};
                2'd2:    rv = m_cause;
                default: rv = {16'h0, 8'd8, 7'h0, m_gen};
            endcase
            m_dat   = (req && !WE) ? rv : 32'h0;
            m_ack   = req;
            m_int   = m_gen && ((m_pend & m_mask) != '0);
            m_cause = cause_of(m_gen, m_pend & m_mask);
            w1c     = (req && WE && ADDR[3:2] == 2'd0) ? DAT_I[N-1:0] : '0;
            rise    = hist[1] & ~hist[2];
            m_pend  = (EDGE & ((m_pend & ~w1c) | rise)) | (~EDGE & hist[1]);
            if (req && WE && ADDR[3:2] == 2'd1) m_mask = DAT_I[N-1:0];
            if (req && WE && ADDR[3:2] == 2'd3) m_gen = DAT_I[0];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_ack",   {31'h0, ACK}, {31'h0, m_ack});
            check("mdl_dat_o", DAT_O,        m_dat);
            check("mdl_int",   {31'h0, INT}, {31'h0, m_int});
            check("mdl_cause", CAUSE,        m_cause);
        end
    end

    // Called and returning on a falling edge.
    task automatic bus(input logic we, input logic [1:0] w, input logic [31:0] d, output logic [31:0] rd);
        STB = 1'b1; WE = we; ADDR = {28'h0, w, 2'b00}; DAT_I = d;
        @(negedge clk);
        check("ack_hi", {31'h0, ACK}, 32'd1);
        rd = DAT_O;
        STB = 1'b0; WE = 1'b0; DAT_I = '0;
        @(negedge clk);
        check("ack_lo", {31'h0, ACK}, 32'd0);
    endtask

    task automatic rd(input logic [1:0] w, input logic [31:0] exp, input string name);
        logic [31:0] v;
        bus(1'b0, w, 32'h0, v);
        check(name, v, exp);
    endtask

    task automatic wr(input logic [1:0] w, input logic [31:0] d);
        logic [31:0] v;
        bus(1'b1, w, d, v);
        check("wr_dat_o", v, 32'h0);
    endtask

    initial begin
        // 1: reset and read-back
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_int",   {31'h0, INT}, 32'd0);
        check("rst_cause", CAUSE, 32'h0);
        RSTN = 1'b1;
        rd(2'd0, 32'h0, "rst_pend");
        rd(2'd1, 32'h0, "rst_mask");
        rd(2'd2, 32'h0, "rst_cause_reg");
        rd(2'd3, 32'h0000_0800, "rst_ctrl");

        // 2: edge latency, sticky pending, W1C
        wr(2'd1, 32'hFF);
        wr(2'd3, 32'h1);
        irq_in[3] = 1'b1;
        @(negedge clk);
        irq_in[3] = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_int_early", {31'h0, INT}, 32'd0);
        @(negedge clk);
        check("t2_int",   {31'h0, INT}, 32'd1);
        check("t2_cause", CAUSE, 32'h6);
        rd(2'd0, 32'h08, "t2_pend");
        wr(2'd0, 32'h08);
        check("t2_int_clr",   {31'h0, INT}, 32'd0);
        check("t2_cause_clr", CAUSE, 32'h0);

        // 3: priority and masking
        irq_in = 8'h22;
        @(negedge clk);
        irq_in = 8'h00;
        repeat (4) @(negedge clk);
        check("t3_cause", CAUSE, 32'h4);
        wr(2'd1, 32'hFD);
        check("t3_cause_mask", CAUSE, 32'h8);
        wr(2'd0, 32'h20);
        check("t3_int_clr", {31'h0, INT}, 32'd0);
        rd(2'd0, 32'h02, "t3_pend_masked");
        wr(2'd0, 32'h02);
        wr(2'd1, 32'hFF);

        // 4: level source, then set/W1C collision
        irq_in[7] = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_cause", CAUSE, 32'hA);
        rd(2'd0, 32'h80, "t4_pend");
        wr(2'd0, 32'h80);
        rd(2'd0, 32'h80, "t4_pend_w1c");
        irq_in[7] = 1'b0;
        repeat (3) @(negedge clk);
        rd(2'd0, 32'h00, "t4_pend_drop");
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        @(negedge clk);
        wr(2'd0, 32'h01);
        rd(2'd0, 32'h01, "t4_collide");
        check("t4_cause0", CAUSE, 32'h3);
        wr(2'd0, 32'h01);

        // 5: global enable, then reset during a request
        irq_in[2] = 1'b1;
        @(negedge clk);
        irq_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        wr(2'd3, 32'h0);
        check("t5_int_gen0",   {31'h0, INT}, 32'd0);
        check("t5_cause_gen0", CAUSE, 32'h0);
        rd(2'd0, 32'h04, "t5_pend_kept");
        wr(2'd3, 32'h1);
        check("t5_int_gen1",   {31'h0, INT}, 32'd1);
        check("t5_cause_gen1", CAUSE, 32'h5);
        STB = 1'b1; WE = 1'b1; ADDR = 32'h4; DAT_I = 32'h55; RSTN = 1'b0;
        @(negedge clk);
        check("t5_rst_ack", {31'h0, ACK}, 32'd0);
        STB = 1'b0; WE = 1'b0; DAT_I = '0;
        @(negedge clk);
        RSTN = 1'b1;
        rd(2'd1, 32'h0, "t5_mask_rst");
        rd(2'd0, 32'h0, "t5_pend_rst");
        rd(2'd3, 32'h0000_0800, "t5_ctrl_rst");
        check("t5_int_rst", {31'h0, INT}, 32'd0);

        // 6: STB held high with reads
        STB = 1'b1; WE = 1'b0; ADDR = 32'hC;
        for (int i = 0; i < 6; i++) begin
            check("t6_ack",   {31'h0, ACK}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("t6_dat_o", DAT_O, (i % 2 == 1) ? 32'h0000_0800 : 32'h0);
            @(negedge clk);
        end
        STB = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller with a Wishbone slave register interface.
- Replaces the fixed two-source OR/priority mux that currently builds CPU_INT and CPU_CAUSE.
- Takes N_SRC raw interrupt lines and synchronises them.
- Latches edge-type requests, applies a per-source mask and a global enable, and drives the CPU INT input and the Cause_in word.
- Sits on the intercon as one slave, and drives Muliti_CPU INT/Cause_in directly.

Parameters:
N_SRC, 8, number of interrupt sources (1..32); index 0 has highest priority.
EDGE_SEL, 32'h0000_00FF, per-source mode: 1 = rising-edge latched, 0 = level; bits at or above N_SRC are ignored.
CAUSE_BASE, 32'h0000_0003, cause code of source 0; source i reports CAUSE_BASE+i.

Ports:
clk  input  1  system clock (clk25 domain).
RSTN  input  1  synchronous active-low reset.
irq_in  input  N_SRC  raw interrupt requests, asynchronous to clk.
STB  input  1  Wishbone strobe/cycle.
WE  input  1  write enable.
ADDR  input  32  byte address; only ADDR[3:2] is decoded.
DAT_I  input  32  write data.
DAT_O  output  32  read data, valid while ACK=1.
ACK  output  1  single-cycle acknowledge.
INT  output  1  interrupt request to the CPU.
CAUSE  output  32  cause code of the highest-priority active source.

Behaviour:
- Reset: evaluated only on a clk edge with RSTN=0. It clears the sync flops, the previous-sample flops, PENDING, MASK and GEN, and sets ACK=0, DAT_O=0, INT=0, CAUSE=0.
- A reset mid-transfer drops ACK at the next edge and discards any write.
- Synchroniser: two flops per source, s2. A further flop p holds the previous s2.
- Edge sources: set_i = s2_i & ~p_i.
- PENDING, edge sources:
  - set by set_i;
  - cleared by a W1C write of 1 to that bit;
  - if set and clear occur in the same cycle, set wins.
- PENDING, level sources: PENDING_i = s2_i, registered each cycle; W1C has no effect.
- Active vector: ACTIVE = PENDING & MASK.
- Registered outputs:
  - INT <= GEN & |ACTIVE.
  - CAUSE <= CAUSE_BASE + index of the lowest-numbered set ACTIVE bit, or 0 when INT would be 0.
  - INT and CAUSE update together in the same cycle.
- Latency, edge source: irq_in high at edge t gives PENDING at t+3 and INT at t+4 (for MASK=1, GEN=1).
- Latency, MASK/GEN change: a write committed at edge w is reflected in INT/CAUSE at w+1.
- Register map (word = ADDR[3:2]):
  - 0 PENDING: R; W1C on edge bits.
  - 1 MASK: RW, N_SRC bits; 1 = enabled.
  - 2 CAUSE: R, current registered CAUSE; writes are ignored.
  - 3 CTRL: bit0 = GEN (RW); bits[15:8] = N_SRC (RO); other bits read 0.
  - Unused high bits read 0.
- Bus handshake:
  - A request is taken on an edge where STB=1 and ACK=0. That edge samples ADDR/WE/DAT_I and commits any write.
  - ACK=1 on the following cycle only, with DAT_O holding the read value captured at the request edge; otherwise DAT_O=0.
  - If STB is held high, ACK toggles, so requests complete every second cycle.
  - Write cycles return DAT_O=0.
- Priority: a fixed-priority scan; lowest index wins. Simultaneous new edges on several sources all latch into PENDING. CAUSE reports only the winner; after it is cleared, the next winner appears one cycle later.
- GEN=0 forces INT=0 and CAUSE=0, but PENDING keeps latching.
- Width: the CAUSE addition is 32-bit and wraps modulo 2^32.

Test Plan:
1. Reset and register read-back:
   - RSTN=0 for 2 clocks, then read words 0..3 -> INT=0, CAUSE=0, reads 0, 0, 0, 32'h0000_0800.
   - Each read has ACK high for exactly 1 cycle, 1 cycle after STB.
2. Edge source latency, sticky pending and W1C:
   - Setup: write MASK=8'hFF and CTRL=1, then pulse irq_in[3] high for 1 clock.
   - -> INT=1 four edges later, CAUSE=32'h6, PENDING=8'h08, and the bit stays latched after irq_in falls.
   - Write word0=8'h08 -> INT=0 and CAUSE=0 on the next cycle.
3. Priority and masking:
   - Raise irq_in[5] and irq_in[1] in the same cycle -> CAUSE=32'h4.
   - Write MASK=8'hFD -> CAUSE=32'h8 one cycle after the write.
   - W1C bit5 -> INT=0.
4. Level source and W1C collision:
   - Use EDGE_SEL=8'h7F. Hold irq_in[7]=1 -> PENDING[7]=1 and CAUSE=32'hA. A W1C of bit7 leaves it set. Dropping irq_in[7] clears it 3 cycles later.
   - Separately, assert a new edge on bit0 on the same edge as a W1C of bit0 -> PENDING[0] stays 1.
5. Global enable and mid-operation reset:
   - With PENDING=8'h04 and MASK=8'hFF, write CTRL=0 -> INT=0 and CAUSE=0 while PENDING stays 8'h04; write CTRL=1 -> INT=1 and CAUSE=32'h5.
   - Assert RSTN=0 while STB=1 and ACK is pending -> ACK=0, nothing written, all registers 0.
6. Back-to-back bus traffic: hold STB=1 with WE=0 for 6 cycles -> ACK pattern 0,1,0,1,0,1, with DAT_O valid only on the ACK cycles.
